// File: rtl/inst_encoder.sv
// inst_encoder: builds 32-bit RV32I instruction words from decoded fields.
// Stage 1 registers the request and its immediate range check. Stage 2
// scatters the fields into the instruction word and holds it for the consumer.
// Both stages can stall, so the block holds up to two words.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (fmt, opcode, rd, rs1, rs2, funct3,
//                       funct7 and imm are sampled on acceptance)
//   out_valid/out_ready word handshake; out_word, out_addr and out_err
//                       describe the word currently offered
//   addr_clr            synchronous reload of out_addr to BASE_ADDR
//   n_words, n_err      transferred-word count (wraps) and error-word count
//                       (saturates)
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic [31:0]      out_addr,
    output logic             out_err,
    input  logic             addr_clr,
    output logic [CNT_W-1:0] n_words,
    output logic [CNT_W-1:0] n_err
);

    localparam logic [2:0]  FMT_R   = 3'd0;
    localparam logic [2:0]  FMT_I   = 3'd1;
    localparam logic [2:0]  FMT_S   = 3'd2;
    localparam logic [2:0]  FMT_B   = 3'd3;
    localparam logic [2:0]  FMT_U   = 3'd4;
    localparam logic [2:0]  FMT_J   = 3'd5;
    localparam logic [2:0]  FMT_SH  = 3'd6;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic              s1_valid;
    logic              s2_valid;
    logic              s1_advances;
    logic              xfer;
    logic [2:0]        s1_fmt;
    logic [6:0]        s1_opcode;
    logic [4:0]        s1_rd;
    logic [4:0]        s1_rs1;
    logic [4:0]        s1_rs2;
    logic [2:0]        s1_funct3;
    logic [6:0]        s1_funct7;
    logic [31:0]       s1_imm;
    logic              s1_err;
    logic              range_err_c;
    logic [31:0]       word_c;
    logic signed [31:0] simm;

    assign simm        = $signed(imm);
    assign s1_advances = !s2_valid || out_ready;
    assign in_ready    = !s1_valid || s1_advances;
    assign out_valid   = s2_valid;
    assign xfer        = s2_valid && out_ready;

    // Immediate range check on the incoming request; fmt 7 is always an error.
    always_comb begin
        range_err_c = 1'b0;
        case (fmt)
            FMT_R:        range_err_c = 1'b0;
            FMT_I, FMT_S: range_err_c = (simm < -32'sd2048) || (simm > 32'sd2047);
            FMT_B:        range_err_c = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
            FMT_U:        range_err_c = |imm[11:0];
            FMT_J:        range_err_c = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
            FMT_SH:       range_err_c = |imm[31:5];
            default:      range_err_c = 1'b1;
        endcase
    end

    // Stage 1: capture fields on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= 3'd0;
            s1_opcode <= 7'd0;
            s1_rd     <= 5'd0;
            s1_rs1    <= 5'd0;
            s1_rs2    <= 5'd0;
            s1_funct3 <= 3'd0;
            s1_funct7 <= 7'd0;
            s1_imm    <= 32'd0;
            s1_err    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fmt    <= fmt;
                s1_opcode <= opcode;
                s1_rd     <= rd;
                s1_rs1    <= rs1;
                s1_rs2    <= rs2;
                s1_funct3 <= funct3;
                s1_funct7 <= funct7;
                s1_imm    <= imm;
                s1_err    <= range_err_c;
            end
        end
    end

    // Bit scatter; out-of-range immediates are simply truncated.
    always_comb begin
        word_c = NOP;
        case (s1_fmt)
            FMT_R:  word_c = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_I:  word_c = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_S:  word_c = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            FMT_B:  word_c = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                              s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_U:  word_c = {s1_imm[31:12], s1_rd, s1_opcode};
            FMT_J:  word_c = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                              s1_rd, s1_opcode};
            FMT_SH: word_c = {s1_funct7, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            default: word_c = NOP;
        endcase
    end

    // Stage 2: output word register, held while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            out_word <= 32'd0;
            out_err  <= 1'b0;
        end else if (s1_advances) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_word <= word_c;
                out_err  <= s1_err;
            end
        end
    end

    // Word address and counters; addr_clr wins over the post-transfer increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_addr <= BASE_ADDR;
            n_words  <= '0;
            n_err    <= '0;
        end else begin
            if (addr_clr) begin
                out_addr <= BASE_ADDR;
            end else if (xfer) begin
                out_addr <= out_addr + 32'd4;
            end
            if (xfer) begin
                n_words <= n_words + CNT_W'(1);
            end
            if (xfer && out_err && (n_err != {CNT_W{1'b1}})) begin
                n_err <= n_err + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Builds 32-bit RV32I instruction words from decoded fields (format, opcode, registers, funct, signed immediate). It is the inverse of the core's immediate decode.
- Used by the self-test and boot loader path to generate instruction-memory images in hardware.
- Two-stage pipeline: stage 1 checks immediate range and selects the format; stage 2 scatters bits and registers the word.
- Valid/ready handshake on both sides, with an auto-incrementing word address and error and word counters.

Parameters:
- BASE_ADDR, 32'h0000_0000, first output address and the reload value for addr_clr.
- CNT_W, 16, width of the n_words and n_err counters.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request fields valid
- in_ready  out  1  encoder can accept a request this cycle
- fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=I-shift, 7=invalid
- opcode  in  7  placed verbatim in word[6:0]
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3  funct3 field
- funct7  in  7  used by R and I-shift only
- imm  in  32  signed byte offset or value
- out_valid  out  1  out_word is valid
- out_ready  in  1  consumer accepts the word
- out_word  out  32  encoded instruction
- out_addr  out  32  address of out_word
- out_err  out  1  immediate out of range, or fmt=7, for this word
- addr_clr  in  1  synchronous reload of the address to BASE_ADDR
- n_words  out  CNT_W  count of accepted output words, wraps
- n_err  out  CNT_W  count of accepted words with out_err set, saturates at all-ones

Behaviour:
- Reset, asynchronous, active-high:
  - both stage valid bits clear, so out_valid=0
  - out_word=0, out_err=0
  - out_addr=BASE_ADDR
  - n_words=0, n_err=0
  - in_ready=1 once reset deasserts.
- Input handshake: a request is accepted when in_valid&&in_ready. Fields are sampled only on acceptance.
- Output handshake: a word is transferred when out_valid&&out_ready.
- Stall rule: in_ready = !s1_valid || s1_advances, where s1_advances = !s2_valid || out_ready. This is a stall-able 2-deep pipeline:
  - no bubbles under full throughput;
  - latency is 2 cycles from acceptance to out_valid;
  - up to 2 words are held when out_ready is low;
  - no loss or duplication.
- Stage 1 range checks; err is set on any violation:
  - I and S: -2048 <= imm <= 2047.
  - B: -4096 <= imm <= 4094 and imm[0]==0.
  - J: -1048576 <= imm <= 1048574 and imm[0]==0.
  - U: imm[11:0]==0.
  - I-shift: 0 <= imm <= 31.
  - R: imm ignored, never an error.
  - fmt=7: err=1.
- Stage 2 packing (opcode always in [6:0]):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - I-shift: {funct7, imm[4:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - fmt=7: word forced to 32'h0000_0013 (NOP), out_err=1.
- Error words: on a range error the word is still produced from the truncated bits, with out_err=1.
- Word and error fields (out_word, out_err) stay stable while out_valid && !out_ready.
- Address and counters:
  - On each output transfer, out_addr += 4 with 32-bit wrap.
  - n_words increments on each transfer and wraps.
  - n_err increments on each transfer with out_err=1 and saturates.
- addr_clr:
  - Next-cycle out_addr=BASE_ADDR; it takes priority over the +4.
  - A transfer in the same cycle still uses the old address.
  - Counters are unaffected.
- Reset mid-operation discards in-flight words immediately; nothing is emitted after reset deasserts until new requests arrive.

Test Plan:
- ADDI: fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_word=0x00500093, out_addr=0x0, out_err=0, out_valid 2 cycles after acceptance.
- SW then BEQ, back-to-back, out_ready=1:
  - SW: fmt=2, opcode=0x23, rs1=1, rs2=2, funct3=2, imm=8 -> 0x0020A423 at addr 0x0.
  - BEQ: fmt=3, opcode=0x63, rs1=0, rs2=0, imm=-4 -> 0xFE000EE3 at addr 0x4 on consecutive cycles.
- JAL and SRAI:
  - JAL: fmt=5, opcode=0x6F, rd=1, imm=2048 -> 0x001000EF.
  - SRAI: fmt=6, opcode=0x13, funct3=5, funct7=0x20, rd=5, rs1=5, imm=3 -> 0x4032D293.
  - n_words=2.
- Errors:
  - fmt=1 with imm=4096 -> out_err=1, word=0x00000093 (rd=1), n_err=1.
  - fmt=3 with imm=6 and funct3=0 -> no error; fmt=3 with imm=7 -> out_err=1.
  - fmt=7 -> word 0x00000013, out_err=1.
- Backpressure: out_ready=0, 4 requests offered -> in_ready drops after 2 accepted; out_word stays stable. Raise out_ready -> all 4 words emitted in order, addrs 0x0, 0x4, 0x8, 0xC, no duplicates.
- Clear and reset:
  - addr_clr in the same cycle as a transfer at addr 0x8 -> that word reports 0x8, the next word reports BASE_ADDR.
  - reset asserted while 2 words are buffered -> out_valid=0 immediately, counters=0, out_addr=BASE_ADDR.
